bus_rr_arbiter_wdt: RTL

//  Round-robin arbiter for the four bus masters, with a per-transaction watchdog.

---
 rtl/bus_rr_arbiter_wdt_pkg.sv | 24 ++
 rtl/bus_rr_arbiter_wdt_counter.sv | 34 +++
 rtl/bus_rr_arbiter_wdt.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bus_rr_arbiter_wdt_pkg.sv
// Shared definitions for the four-master round-robin arbiter with transaction watchdog.
package bus_rr_arbiter_wdt_pkg;

  localparam int unsigned BusMasterCh = 4;
  localparam int unsigned BusIdxW     = 2;

  // Active-low bus signalling levels.
  localparam logic BusEnable  = 1'b0;
  localparam logic BusDisable = 1'b1;

  typedef logic [BusIdxW-1:0] bus_idx_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwn   = 2'd1,
    StAbort = 2'd2
  } bus_arb_state_e;

  typedef struct packed {
    logic     valid;
    bus_idx_t idx;
  } rr_pick_t;

endpackage

// File: rtl/bus_rr_arbiter_wdt_counter.sv
// Saturating stall counter with synchronous clear and terminal-count flag.
module bus_wdt_counter #(
  parameter int unsigned Width   = 9,
  parameter int unsigned TermVal = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == Width'(TermVal));

endmodule

// File: rtl/bus_rr_arbiter_wdt.sv
// Round-robin bus arbiter for four masters with active-low grants and a per-owner
// watchdog that aborts accesses whose slave never returns ready.
module bus_rr_arbiter_wdt
  import bus_rr_arbiter_wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned WDT_W   = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  input  logic       s_as_,
  input  logic       m_rdy_,
  output logic       to_err_,
  output logic [1:0] to_id,
  output logic       bus_busy
);

  localparam bit          WdtEn   = (TIMEOUT != 0);
  localparam int unsigned WdtTerm = WdtEn ? TIMEOUT - 1 : 0;

  // First requester after `last` in circular order; `last` itself is checked last.
  function automatic rr_pick_t rr_search(input logic [BusMasterCh-1:0] req_n,
                                         input bus_idx_t last);
    rr_pick_t pick;
    bus_idx_t cand;
    pick = '0;
    for (int i = 1; i <= int'(BusMasterCh); i++) begin
      cand = last + bus_idx_t'(i);
      if (!pick.valid && (req_n[cand] == BusEnable)) begin
        pick.valid = 1'b1;
        pick.idx   = cand;
      end
    end
    return pick;
  endfunction

  bus_arb_state_e         state_d, state_q;
  bus_idx_t               owner_d, owner_q;
  bus_idx_t               last_d, last_q;
  logic [BusMasterCh-1:0] grnt_d, grnt_q;
  logic                   to_err_d, to_err_q;
  bus_idx_t               to_id_d, to_id_q;

  logic [BusMasterCh-1:0] req_n;
  logic                   stall;
  logic                   wdt_clr;
  logic                   wdt_term;
  rr_pick_t               pick_idle, pick_rel;

  assign req_n     = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign stall     = (s_as_ == BusEnable) && (m_rdy_ == BusDisable);
  assign pick_idle = rr_search(req_n, last_q);
  assign pick_rel  = rr_search(req_n, owner_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    grnt_d   = grnt_q;
    to_err_d = BusDisable;
    to_id_d  = to_id_q;
    wdt_clr  = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pick_idle.valid) begin
          grnt_d              = '1;
          grnt_d[pick_idle.idx] = BusEnable;
          owner_d             = pick_idle.idx;
          state_d             = StOwn;
        end
      end
      StOwn: begin
        // Release beats abort so a transfer ending on the terminal cycle is not flagged.
        if (req_n[owner_q] == BusDisable) begin
          last_d = owner_q;
          grnt_d = '1;
          if (pick_rel.valid) begin
            grnt_d[pick_rel.idx] = BusEnable;
            owner_d              = pick_rel.idx;
          end else begin
            state_d = StIdle;
          end
        end else if (WdtEn && wdt_term && stall) begin
          grnt_d   = '1;
          to_err_d = BusEnable;
          to_id_d  = owner_q;
          last_d   = owner_q;
          state_d  = StAbort;
        end else begin
          wdt_clr = !stall || !WdtEn;
        end
      end
      StAbort: begin
        grnt_d  = '1;
        state_d = StIdle;
      end
      default: begin
        grnt_d  = '1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      last_q   <= bus_idx_t'(BusMasterCh - 1);
      grnt_q   <= '1;
      to_err_q <= BusDisable;
      to_id_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      grnt_q   <= grnt_d;
      to_err_q <= to_err_d;
      to_id_q  <= to_id_d;
    end
  end

  bus_wdt_counter #(
    .Width   (WDT_W),
    .TermVal (WdtTerm)
  ) u_wdt (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (wdt_clr),
    .inc_i  (stall),
    .term_o (wdt_term)
  );

  assign m0_grnt_ = grnt_q[0];
  assign m1_grnt_ = grnt_q[1];
  assign m2_grnt_ = grnt_q[2];
  assign m3_grnt_ = grnt_q[3];
  assign to_err_  = to_err_q;
  assign to_id    = to_id_q;
  assign bus_busy = ~&grnt_q;

endmodule
